// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
//
// Purpose: accepts one operation at a time from requester 0 or 1, drives the
// shared ALU from registers for one cycle, captures the ALU result and
// presents it as a response until the consumer takes it.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   - round-robin between requesters when both are valid
//   undefined - fixed priority, requester 0 wins
//
// Ports:
//   clock, resetn                 clock, synchronous active-low reset
//   rN_valid/rN_ready             requester N handshake (N = 0,1)
//   rN_a, rN_b, rN_aluc           requester N operands and opcode
//   alu_a, alu_b, alu_aluc        registered drive to the shared ALU
//   alu_s, alu_z                  combinational ALU result and zero flag
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_s, rsp_z          response requester index, result, zero flag
//   busy                          high whenever an operation is in flight

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [3:0]       r0_aluc,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [3:0]       r1_aluc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_z,
    input  logic             rsp_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             idx_q, idx_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_aluc_q, alu_aluc_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
    logic             rsp_z_q, rsp_z_d;

    logic             grant_any;
    logic             sel;

`ifdef ALU_ARB_RR_EN
    // Points at the requester preferred on the next contended grant.
    logic             ptr_q, ptr_d;
`endif

    // Ready is gated by resetn so no handshake can complete on a reset edge.
    assign grant_any = (state_q == S_IDLE) && resetn && (r0_valid || r1_valid);

    always_comb begin
        sel = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (r0_valid && r1_valid) begin
            sel = ptr_q;
        end else begin
            sel = ~r0_valid;
        end
`else
        sel = ~r0_valid;
`endif
    end

    assign r0_ready = grant_any && !sel;
    assign r1_ready = grant_any && sel;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_aluc_d = alu_aluc_q;
        rsp_id_d   = rsp_id_q;
        rsp_s_d    = rsp_s_q;
        rsp_z_d    = rsp_z_q;
`ifdef ALU_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d    = S_EXEC;
                    idx_d      = sel;
                    alu_a_d    = sel ? r1_a : r0_a;
                    alu_b_d    = sel ? r1_b : r0_b;
                    alu_aluc_d = sel ? r1_aluc : r0_aluc;
`ifdef ALU_ARB_RR_EN
                    ptr_d      = ~sel;
`endif
                end
            end
            S_EXEC: begin
                // ALU inputs have been stable since the accept edge.
                rsp_s_d  = alu_s;
                rsp_z_d  = alu_z;
                rsp_id_d = idx_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_aluc_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_s_q    <= '0;
            rsp_z_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_aluc_q <= alu_aluc_d;
            rsp_id_q   <= rsp_id_d;
            rsp_s_q    <= rsp_s_d;
            rsp_z_q    <= rsp_z_d;
`ifdef ALU_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_aluc  = alu_aluc_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_z     = rsp_z_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter

module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [3:0]  r0_aluc, r1_aluc;
    logic [31:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_aluc;
    logic        alu_z;
    logic        rsp_valid, rsp_id, rsp_z, rsp_ready, busy;
    logic [31:0] rsp_s;

    always #5 clock = ~clock;

    alu_arbiter #(.WIDTH(32)) dut (
        .clock(clock), .resetn(resetn),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_aluc(r0_aluc),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_aluc(r1_aluc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_z(rsp_z),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // External ALU: 0000 add, 0100 subtract, a few logic ops, anything else a fixed mix.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a ^ b;
            4'd4:    return a - b;
            default: return a - (b << 1);
        endcase
    endfunction

    assign alu_s = alu_f(alu_a, alu_b, alu_aluc);
    assign alu_z = (alu_s == 32'd0);

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state: at most one operation outstanding.
    int          cyc = 0;
    bit          outst = 1'b0;
    int          acc_cyc = 0;
    bit          exp_id = 1'b0;
    logic [31:0] exp_s = '0;
    bit          exp_z = 1'b0;
    logic [31:0] last_a = '0, last_b = '0;
    logic [3:0]  last_op = '0;
    bit          pref = 1'b0;
    bit          just_reset = 1'b0;
    bit          acc0 = 1'b0, acc1 = 1'b0;
    int          rsp_count = 0;
    int          grants[$];
    int          acc_cycles[$];

    always @(negedge clock) begin
        bit any, w, exp_valid;
        cyc++;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!resetn) begin
            check_eq("ready_in_reset", {r0_ready, r1_ready}, 2'b00);
            outst = 1'b0; pref = 1'b0;
            last_a = '0; last_b = '0; last_op = '0;
            just_reset = 1'b1;
        end else begin
            if (just_reset) begin
                check_eq("reset_rsp", {rsp_valid, rsp_id, rsp_z, rsp_s}, 35'd0);
                just_reset = 1'b0;
            end
            check_eq("busy", busy, outst);
            check_eq("alu_hold_a_op", {alu_aluc, alu_a}, {last_op, last_a});
            check_eq("alu_hold_b", alu_b, last_b);
            exp_valid = outst && (cyc >= acc_cyc + 2);
            check_eq("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid)
                check_eq("rsp_data", {rsp_id, rsp_z, rsp_s}, {exp_id, exp_z, exp_s});
            any = !outst && (r0_valid || r1_valid);
            if (r0_valid && r1_valid) w = RR ? pref : 1'b0;
            else                      w = !r0_valid;
            check_eq("ready", {r0_ready, r1_ready}, {any && !w, any && w});
            if (exp_valid && rsp_ready) begin
                outst = 1'b0;
                rsp_count++;
            end
            if (any) begin
                outst   = 1'b1;
                acc_cyc = cyc;
                exp_id  = w;
                last_a  = w ? r1_a : r0_a;
                last_b  = w ? r1_b : r0_b;
                last_op = w ? r1_aluc : r0_aluc;
                exp_s   = alu_f(last_a, last_b, last_op);
                exp_z   = (exp_s == 32'd0);
                pref    = !w;
                grants.push_back(int'(w));
                acc_cycles.push_back(cyc);
                acc0 = !w;
                acc1 = w;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grants(input int n, input int limit);
        int start = grants.size();
        int k = 0;
        while (grants.size() < start + n && k < limit) begin
            step();
            k++;
        end
        check_eq("grant_timeout", grants.size() >= start + n, 1'b1);
    endtask

    task automatic rand_op(output logic [31:0] a, output logic [31:0] b, output logic [3:0] op);
        a  = $urandom;
        b  = ($urandom_range(3, 0) == 0) ? a : $urandom;
        op = 4'($urandom_range(5, 0));
    endtask

    initial begin
        int start, rc;
        resetn = 1'b0; rsp_ready = 1'b0;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_aluc = '0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_aluc = '0;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // r0 alone: 5 + 3
        r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd3; r0_aluc = 4'b0000; rsp_ready = 1'b1;
        wait_grants(1, 10);
        r0_valid = 1'b0;
        @(negedge clock);
        @(negedge clock); #1;
        check_eq("d1_rsp", {rsp_valid, rsp_id, rsp_z, rsp_s}, {1'b1, 1'b0, 1'b0, 32'd8});
        step(); step();

        // r1 alone: 7 - 7 held with rsp_ready low
        rsp_ready = 1'b0;
        r1_valid = 1'b1; r1_a = 32'd7; r1_b = 32'd7; r1_aluc = 4'b0100;
        wait_grants(1, 10);
        r1_valid = 1'b0;
        @(negedge clock);
        repeat (4) begin
            @(negedge clock); #1;
            check_eq("d2_hold", {rsp_valid, rsp_id, rsp_z, rsp_s}, {1'b1, 1'b1, 1'b1, 32'd0});
        end
        step();
        rsp_ready = 1'b1;
        step(); step();

        // Both valid continuously
        rand_op(r0_a, r0_b, r0_aluc);
        rand_op(r1_a, r1_b, r1_aluc);
        r0_valid = 1'b1; r1_valid = 1'b1;
        start = grants.size();
        wait_grants(4, 40);
        r0_valid = 1'b0; r1_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("d3_grant%0d", i), grants[start + i], RR ? (i % 2) : 0);
        repeat (4) step();

        // Back-to-back from r0 with rsp_ready high
        r0_valid = 1'b1;
        start = acc_cycles.size();
        wait_grants(4, 40);
        r0_valid = 1'b0;
        for (int i = 1; i < 4; i++)
            check_eq($sformatf("d4_spacing%0d", i), acc_cycles[start + i] - acc_cycles[start + i - 1], 3);
        repeat (4) step();

        // Reset while EXEC aborts the op; the next one completes
        r0_valid = 1'b1; rand_op(r0_a, r0_b, r0_aluc);
        wait_grants(1, 10);
        rc = rsp_count;
        resetn = 1'b0; r0_valid = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clock); #1;
        check_eq("d5_after_reset", {busy, rsp_valid}, 2'b00);
        step();
        r0_valid = 1'b1; rand_op(r0_a, r0_b, r0_aluc);
        wait_grants(1, 10);
        r0_valid = 1'b0;
        repeat (4) step();
        check_eq("d5_rsp_count", rsp_count, rc + 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step();
            resetn = ($urandom_range(149, 0) != 0);
            rsp_ready = ($urandom_range(9, 0) < 7);
            if (acc0 || !r0_valid) begin
                r0_valid = $urandom_range(1, 0);
                rand_op(r0_a, r0_b, r0_aluc);
            end else if ($urandom_range(7, 0) == 0) begin
                rand_op(r0_a, r0_b, r0_aluc);
            end
            if (acc1 || !r1_valid) begin
                r1_valid = $urandom_range(1, 0);
                rand_op(r1_a, r1_b, r1_aluc);
            end else if ($urandom_range(7, 0) == 0) begin
                rand_op(r1_a, r1_b, r1_aluc);
            end
        end
        resetn = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) step();
        check_eq("drain_idle", {busy, rsp_valid}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
